// File: rtl/dreg_bank_pkg.sv
// Shared encodings for dreg_bank: channel operation modes and snapshot FSM states.
package dreg_bank_pkg;

   localparam int unsigned MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_LOAD = 3'd0;
   localparam logic [MODE_W-1:0] MODE_HOLD = 3'd1;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
   localparam logic [MODE_W-1:0] MODE_CLR  = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_PRESENT = 2'd2
   } snap_state_e;

endpackage

// File: rtl/dreg_channel.sv
// One WIDTH-bit edge-triggered register with enable and load/hold/shift/clear modes.
module dreg_channel
   import dreg_bank_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              En,
   input  logic [MODE_W-1:0] Mode,
   input  logic [WIDTH-1:0]  D,
   input  logic              Sin,
   output logic [WIDTH-1:0]  Q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Unused encodings fall through to hold.
   always_comb begin
      q_d = q_q;
      if (En) begin
         case (Mode)
            MODE_LOAD: q_d = D;
            MODE_HOLD: q_d = q_q;
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], Sin};
            MODE_SHR:  q_d = {Sin, q_q[WIDTH-1:1]};
            MODE_CLR:  q_d = '0;
            default:   q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

endmodule

// File: rtl/dreg_bank.sv
// Bank of CHANNELS clocked registers plus an atomic snapshot presented over valid/ready.
module dreg_bank
   import dreg_bank_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CHANNELS-1:0]         En,
   input  logic [MODE_W-1:0]           Mode,
   input  logic [CHANNELS*WIDTH-1:0]   D,
   input  logic [CHANNELS-1:0]         Sin,
   output logic [CHANNELS*WIDTH-1:0]   Q,
   input  logic                        snap_req,
   output logic                        snap_busy,
   output logic                        snap_valid,
   input  logic                        snap_ready,
   output logic [CHANNELS*WIDTH-1:0]   snap_data
);

   localparam int unsigned BUS_W = CHANNELS * WIDTH;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      dreg_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .En    (En[i]),
         .Mode  (Mode),
         .D     (D[i*WIDTH +: WIDTH]),
         .Sin   (Sin[i]),
         .Q     (Q[i*WIDTH +: WIDTH])
      );
   end

   snap_state_e      state_q, state_d;
   logic [BUS_W-1:0] snap_q,  snap_d;
   logic             valid_q, valid_d;
   logic             busy_q,  busy_d;

   // Q here is the registered bank value, so CAPTURE sees the pre-update contents.
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (snap_req) begin
               state_d = S_CAPTURE;
               busy_d  = 1'b1;
            end
         end
         S_CAPTURE: begin
            snap_d  = Q;
            state_d = S_PRESENT;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
         S_PRESENT: begin
            if (snap_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         snap_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign snap_data  = snap_q;
   assign snap_valid = valid_q;
   assign snap_busy  = busy_q;

endmodule

// File: tb/tb_dreg_bank.sv
// Directed and randomized bench for dreg_bank against a behavioural reference model.
module tb_dreg_bank;

   localparam int unsigned C  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned BW = C * W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [C-1:0]  En;
   logic [2:0]    Mode;
   logic [BW-1:0] D;
   logic [C-1:0]  Sin;
   logic [BW-1:0] Q;
   logic          snap_req;
   logic          snap_busy;
   logic          snap_valid;
   logic          snap_ready;
   logic [BW-1:0] snap_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dreg_bank #(.CHANNELS(C), .WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .En         (En),
      .Mode       (Mode),
      .D          (D),
      .Sin        (Sin),
      .Q          (Q),
      .snap_req   (snap_req),
      .snap_busy  (snap_busy),
      .snap_valid (snap_valid),
      .snap_ready (snap_ready),
      .snap_data  (snap_data)
   );

   // Reference model: per-channel values, the frozen snapshot, and two flags
   // saying whether a capture is due at the next edge or a snapshot is on offer.
   logic [W-1:0] mq [C];
   logic [W-1:0] ms [C];
   bit           m_capt;
   bit           m_valid;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] pack_q();
      logic [BW-1:0] r;
      for (int i = 0; i < C; i++) r[i*W +: W] = mq[i];
      return r;
   endfunction

   function automatic logic [BW-1:0] pack_s();
      logic [BW-1:0] r;
      for (int i = 0; i < C; i++) r[i*W +: W] = ms[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < C; i++) begin
         mq[i] = '0;
         ms[i] = '0;
      end
      m_capt  = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic model_edge();
      logic [W-1:0] old [C];
      bit idle;
      for (int i = 0; i < C; i++) old[i] = mq[i];
      for (int i = 0; i < C; i++) begin
         if (En[i]) begin
            case (Mode)
               3'd0: mq[i] = D[i*W +: W];
               3'd2: mq[i] = W'((old[i] << 1) | W'(Sin[i]));
               3'd3: mq[i] = W'((old[i] >> 1) | (W'(Sin[i]) << (W-1)));
               3'd4: mq[i] = '0;
               default: mq[i] = old[i];
            endcase
         end
      end
      idle = !m_capt && !m_valid;
      if (m_valid && snap_ready) begin
         m_valid = 1'b0;
      end else if (m_capt) begin
         for (int i = 0; i < C; i++) ms[i] = old[i];
         m_capt  = 1'b0;
         m_valid = 1'b1;
      end else if (idle && snap_req) begin
         m_capt = 1'b1;
      end
   endtask

   task automatic compare();
      chk("Q", 64'(Q), 64'(pack_q()));
      chk("snap_valid", 64'(snap_valid), 64'(m_valid));
      chk("snap_busy", 64'(snap_busy), 64'(m_capt | m_valid));
      chk("snap_data", 64'(snap_data), 64'(pack_s()));
   endtask

   // Caller sits just after a falling edge with inputs already driven.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic mid_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk({tag, "_Q"}, 64'(Q), 64'd0);
      chk({tag, "_valid"}, 64'(snap_valid), 64'd0);
      chk({tag, "_busy"}, 64'(snap_busy), 64'd0);
      chk({tag, "_data"}, 64'(snap_data), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      En         = '0;
      Mode       = 3'd1;
      D          = '0;
      Sin        = '0;
      snap_req   = 1'b0;
      snap_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("init_Q", 64'(Q), 64'd0);
      chk("init_valid", 64'(snap_valid), 64'd0);
      rst_n = 1'b1;

      // Fill all ones, then reset mid-cycle with load still requested.
      D = '1; En = '1; Mode = 3'd0;
      step();
      chk("fill_Q", 64'(Q), 64'hFFFF_FFFF);
      mid_reset("rst_mid");

      // Load with partial enable, then hold.
      D = 32'hA1B2_C3D4; En = 4'b0101; Mode = 3'd0;
      step();
      chk("load_Q", 64'(Q), 64'h00B2_00D4);
      En = 4'b1111; Mode = 3'd1;
      step();
      chk("hold_Q", 64'(Q), 64'h00B2_00D4);

      // Shifts on channel 0 and an unused mode encoding.
      D = 32'h0000_0081; En = 4'b0001; Mode = 3'd0;
      step();
      Mode = 3'd2; Sin = 4'b0001;
      step();
      chk("shl_Q", 64'(Q), 64'h00B2_0003);
      Mode = 3'd3; Sin = 4'b0000;
      step();
      chk("shr_Q", 64'(Q), 64'h00B2_0001);
      Mode = 3'd6; Sin = 4'b1111; En = 4'b1111;
      step();
      chk("mode6_Q", 64'(Q), 64'h00B2_0001);

      // Snapshot coherence: a load on the capture edge must not leak into snap_data.
      D = 32'h0000_0010; En = 4'b0001; Mode = 3'd0;
      step();
      snap_req = 1'b1; Mode = 3'd1;
      step();
      chk("cap_busy", 64'(snap_busy), 64'd1);
      chk("cap_valid", 64'(snap_valid), 64'd0);
      snap_req = 1'b0; D = 32'h0000_0020; Mode = 3'd0;
      step();
      chk("coh_data", 64'(snap_data), 64'h00B2_0010);
      chk("coh_Q", 64'(Q), 64'h00B2_0020);
      chk("coh_valid", 64'(snap_valid), 64'd1);

      // Back-pressure with Q changing every cycle and a stray request.
      En = 4'b1111; Mode = 3'd0; snap_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         D = BW'($urandom);
         snap_req = (k == 2);
         step();
         chk("bp_data", 64'(snap_data), 64'h00B2_0010);
         chk("bp_valid", 64'(snap_valid), 64'd1);
      end
      snap_req = 1'b0; snap_ready = 1'b1; Mode = 3'd1;
      step();
      chk("hs_valid", 64'(snap_valid), 64'd0);
      chk("hs_busy", 64'(snap_busy), 64'd0);
      snap_ready = 1'b0;
      step();
      chk("post_hs_busy", 64'(snap_busy), 64'd0);

      // Reset while presenting, then a fresh snapshot.
      snap_req = 1'b1;
      step();
      snap_req = 1'b0;
      step();
      chk("pre_rst_valid", 64'(snap_valid), 64'd1);
      mid_reset("rst_present");
      D = 32'h1234_5678; En = 4'b1111; Mode = 3'd0;
      step();
      snap_req = 1'b1; Mode = 3'd1;
      step();
      snap_req = 1'b0;
      step();
      chk("resnap_valid", 64'(snap_valid), 64'd1);
      chk("resnap_data", 64'(snap_data), 64'h1234_5678);
      snap_ready = 1'b1;
      step();
      chk("resnap_done", 64'(snap_valid), 64'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         En         = C'($urandom);
         Mode       = 3'($urandom_range(0, 7));
         D          = BW'($urandom);
         Sin        = C'($urandom);
         snap_req   = ($urandom_range(0, 3) == 0);
         snap_ready = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 149) == 0) begin
            mid_reset("rst_rand");
         end else begin
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
